// File: rtl/reset_seq_pkg.sv
// ---------------------------------------------------------------------------
// reset_seq_pkg
//   Shared definitions for the staggered reset sequencer:
//     - seq_state_t : FSM state encoding (HOLD=0, ASSERT=1, RELEASE=2, RUN=3)
//     - CAUSE_*     : bit positions of the request sources inside the
//                     request/cause vector (POR, SOFT, ASYNC)
//     - max_int     : elaboration-time helper for sizing counters
// ---------------------------------------------------------------------------
package reset_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    ASSERT  = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } seq_state_t;

  localparam int CAUSE_W     = 3;
  localparam int CAUSE_POR   = 0;
  localparam int CAUSE_SOFT  = 1;
  localparam int CAUSE_ASYNC = 2;

  // Larger of two integers; used to size the shared stretch/stagger counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_seq_async_capture.sv
// ---------------------------------------------------------------------------
// reset_seq_async_capture
//   Captures an asynchronous request of any width (including glitches much
//   shorter than a clock period) in an async-set flag, then moves it into the
//   clock domain through a SYNC_STAGES-deep synchroniser. The flag is cleared
//   once the synchroniser output shows it, so a short pulse is seen once;
//   a held level keeps the flag set for as long as the level lasts.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset, clears flag and chain
//   async_req  in   asynchronous active-high request
//   async_sync out  synchronised request, high while the capture is pending
// ---------------------------------------------------------------------------
module reset_seq_async_capture #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_req,
  output logic async_sync
);

  logic                   req_flag;
  logic [SYNC_STAGES-1:0] sync_chain;

  // Capture flag. The request input acts as an asynchronous set so that a
  // glitch between clock edges is never lost. While the request is still
  // high the set keeps winning over the acknowledge; once it has dropped,
  // the flag clears on the first edge where the synchroniser output already
  // reflects the capture.
  always_ff @(posedge clk or posedge async_req or negedge rst_n) begin
    if (!rst_n) begin
      req_flag <= 1'b0;
    end else if (async_req) begin
      req_flag <= 1'b1;
    end else if (async_sync) begin
      req_flag <= 1'b0;
    end
  end

  // Plain shift-register synchroniser for the captured flag. Its last stage
  // is both the request seen by the sequencer and the acknowledge back to
  // the capture flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_chain <= '0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], req_flag};
    end
  end

  assign async_sync = sync_chain[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// ---------------------------------------------------------------------------
// reset_sequencer
//   Combines three reset sources (board reset rst_n, an asynchronous
//   request, a synchronous soft request), stretches the reset for STRETCH
//   cycles after the last request, then releases NUM_CHANNELS active-high
//   reset outputs one after another, STAGGER cycles apart, bit 0 first.
//
// Parameters:
//   NUM_CHANNELS  number of reset_out bits (1..8)
//   SYNC_STAGES   synchroniser depth for rst_n release and async_req (>=2)
//   STRETCH       cycles all outputs stay high after the last request (>=2)
//   STAGGER       cycles between consecutive channel releases (>=1)
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset (async assert, sync release)
//   async_req  in   asynchronous request, any pulse or glitch counts
//   soft_req   in   synchronous request, sampled on posedge clk
//   reset_out  out  sequenced active-high resets [NUM_CHANNELS-1:0]
//   busy       out  high while any reset_out bit is high
//   done       out  high once every channel is released
//
// Optional feature, enabled by defining RESET_SEQ_CAUSE_EN:
//   cause_clr  in   synchronous clear of the sticky cause bits
//   cause      out  sticky reset cause {ASYNC, SOFT, POR}, reset value 3'b001
// ---------------------------------------------------------------------------
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_CHANNELS = 3,
  parameter int SYNC_STAGES  = 2,
  parameter int STRETCH      = 4,
  parameter int STAGGER      = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    async_req,
  input  logic                    soft_req,
`ifdef RESET_SEQ_CAUSE_EN
  input  logic                    cause_clr,
  output logic [2:0]              cause,
`endif
  output logic [NUM_CHANNELS-1:0] reset_out,
  output logic                    busy,
  output logic                    done
);

  localparam int CNT_W = $clog2(max_int(STRETCH, STAGGER)) + 1;
  localparam int IDX_W = $clog2(NUM_CHANNELS) + 1;
  // The FSM state register acts as the final stage of the rst_n release
  // synchroniser, so only SYNC_STAGES-1 dedicated flops are needed.
  localparam int RST_W = SYNC_STAGES - 1;

  localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_CHANNELS - 1);

  // Reject unusable configurations while elaborating.
  if (NUM_CHANNELS < 1 || NUM_CHANNELS > 8) begin : g_bad_channels
    $error("reset_sequencer: NUM_CHANNELS must be within 1..8");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("reset_sequencer: SYNC_STAGES must be at least 2");
  end
  if (STRETCH < 2) begin : g_bad_stretch
    $error("reset_sequencer: STRETCH must be at least 2");
  end
  if (STAGGER < 1) begin : g_bad_stagger
    $error("reset_sequencer: STAGGER must be at least 1");
  end

  seq_state_t         state;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   idx;
  logic [RST_W-1:0]   rst_sync;
  logic               async_sync;
  logic [CAUSE_W-1:0] req_src;
  logic               req;

  // Asynchronous request capture and synchronisation.
  reset_seq_async_capture #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_async_capture (
    .clk        (clk),
    .rst_n      (rst_n),
    .async_req  (async_req),
    .async_sync (async_sync)
  );

  // rst_n release synchroniser: cleared while rst_n is low, then shifts in
  // ones. Its last bit tells the FSM that the release has fully propagated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= '0;
    end else begin
      rst_sync <= (rst_sync << 1) | RST_W'(1);
    end
  end

  // Request sources collected in cause-bit order, so the same vector feeds
  // both the sequencer and the optional sticky cause register. The POR slot
  // is only ever set by rst_n itself, never as a running request.
  always_comb begin
    req_src              = '0;
    req_src[CAUSE_POR]   = 1'b0;
    req_src[CAUSE_SOFT]  = soft_req;
    req_src[CAUSE_ASYNC] = async_sync;
  end

  assign req = |req_src;

  // Sequencer FSM with registered outputs. Any request outside HOLD has
  // priority over counting and releasing: it re-asserts every channel and
  // restarts the stretch, which also means a channel due for release on
  // the same edge stays asserted. Channels are released from bit 0 upward
  // by shifting zeros in from the bottom of reset_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HOLD;
      cnt       <= '0;
      idx       <= '0;
      reset_out <= '1;
      busy      <= 1'b1;
      done      <= 1'b0;
    end else begin
      case (state)
        HOLD: begin
          if (rst_sync[RST_W-1]) begin
            state <= ASSERT;
            cnt   <= '0;
          end
        end

        ASSERT: begin
          if (req) begin
            cnt <= '0;
          end else if (cnt == STRETCH_LAST) begin
            cnt       <= '0;
            reset_out <= reset_out << 1;
            if (NUM_CHANNELS == 1) begin
              state <= RUN;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= RELEASE;
              idx   <= IDX_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        RELEASE: begin
          if (req) begin
            state     <= ASSERT;
            cnt       <= '0;
            idx       <= '0;
            reset_out <= '1;
          end else if (cnt == STAGGER_LAST) begin
            cnt       <= '0;
            reset_out <= reset_out << 1;
            if (idx == IDX_LAST) begin
              state <= RUN;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        RUN: begin
          if (req) begin
            state     <= ASSERT;
            cnt       <= '0;
            idx       <= '0;
            reset_out <= '1;
            busy      <= 1'b1;
            done      <= 1'b0;
          end
        end

        default: begin
          state     <= HOLD;
          cnt       <= '0;
          idx       <= '0;
          reset_out <= '1;
          busy      <= 1'b1;
          done      <= 1'b0;
        end
      endcase
    end
  end

`ifdef RESET_SEQ_CAUSE_EN
  // Sticky reset cause. rst_n leaves only the POR bit set; afterwards a
  // request sets its bit on the edge it is seen. A clear and a set on the
  // same edge leave the newly set bit standing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cause            <= '0;
      cause[CAUSE_POR] <= 1'b1;
    end else begin
      cause <= (cause_clr ? 3'b000 : cause) | req_src;
    end
  end
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_reset_sequencer
//   Self-checking bench for reset_sequencer with default parameters.
//   Expected outputs come from a timing model: each channel k is released
//   STRETCH + k*STAGGER edges after the most recent "restart" edge (hold
//   exit or the last edge on which a request was seen). Covers the cause
//   register when RESET_SEQ_CAUSE_EN is defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_reset_sequencer;

  localparam int NCH = 3;
  localparam int SS  = 2;
  localparam int STR = 4;
  localparam int STG = 2;
  localparam int FAR = 1 << 30;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           async_req = 1'b0;
  logic           soft_req = 1'b0;
  logic [NCH-1:0] reset_out;
  logic           busy;
  logic           done;
`ifdef RESET_SEQ_CAUSE_EN
  logic           cause_clr = 1'b0;
  logic [2:0]     cause;
  logic [2:0]     exp_cause = 3'b001;
`endif

  reset_sequencer #(
    .NUM_CHANNELS (NCH),
    .SYNC_STAGES  (SS),
    .STRETCH      (STR),
    .STAGGER      (STG)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .async_req (async_req),
    .soft_req  (soft_req),
`ifdef RESET_SEQ_CAUSE_EN
    .cause_clr (cause_clr),
    .cause     (cause),
`endif
    .reset_out (reset_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state: edge count since rst_n release, restart edge, and the
  // window of edges on which the synchronised async request is seen.
  int             edge_n   = 0;
  int             base     = SS;
  int             async_lo = 1;
  int             async_hi = 0;
  bit             check_en = 1'b0;
  logic [NCH-1:0] exp_out  = '1;

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
    end
  endtask

  // Reference model: hold exit is edge SS; later, any request edge becomes
  // the new restart point; channel k is high until restart + STR + k*STG.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_n   = 0;
      base     = SS;
      async_lo = 1;
      async_hi = 0;
`ifdef RESET_SEQ_CAUSE_EN
      exp_cause = 3'b001;
`endif
    end else begin
      bit in_win;
      edge_n++;
      in_win = (edge_n >= async_lo) && (edge_n <= async_hi);
      if ((soft_req || in_win) && edge_n > SS) base = edge_n;
`ifdef RESET_SEQ_CAUSE_EN
      if (cause_clr) exp_cause = 3'b000;
      if (soft_req) exp_cause[1] = 1'b1;
      if (in_win) exp_cause[2] = 1'b1;
`endif
    end
    for (int k = 0; k < NCH; k++) exp_out[k] = (edge_n < base + STR + k * STG);
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("reset_out", reset_out, exp_out);
      checkOutput("busy", busy, |exp_out);
      checkOutput("done", done, exp_out == '0);
`ifdef RESET_SEQ_CAUSE_EN
      checkOutput("cause", cause, exp_cause);
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitEdge(input int target);
    int guard = 0;
    while (edge_n < target && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (edge_n < target) checkOutput("wait_bound", edge_n, target);
  endtask

  // Called on a negedge. kind: 0 idle, 1 soft pulse, 2 async glitch,
  // 3 async level, 4 board reset pulse. The async cases also register the
  // edge window over which the synchronised request is visible: from
  // first-capture edge m plus SS, to max(fall edge, m+SS) plus SS.
  task automatic applyStimulus(input int kind, input int len);
    int m;
    int p;
    case (kind)
      1: begin
        soft_req = 1'b1;
        tick(len);
        soft_req = 1'b0;
      end
      2: begin
        #1 async_req = 1'b1;
        m = edge_n + 1;
        async_lo = m + SS;
        async_hi = m + SS + SS;
        #2 async_req = 1'b0;
        tick(1);
      end
      3: begin
        async_req = 1'b1;
        m = edge_n + 1;
        async_lo = m + SS;
        async_hi = FAR;
        tick(len);
        async_req = 1'b0;
        p = edge_n + 1;
        async_hi = ((p > m + SS) ? p : m + SS) + SS;
      end
      4: begin
        #2 rst_n = 1'b0;
        #1 checkOutput("async_rst_now", reset_out, {NCH{1'b1}});
        @(negedge clk);
        rst_n = 1'b1;
      end
      default: tick(len);
    endcase
  endtask

  initial begin
    int rel;
    // Reset state while rst_n is held low.
    tick(3);
    checkOutput("rst_reset_out", reset_out, 3'b111);
    checkOutput("rst_busy", busy, 1'b1);
    checkOutput("rst_done", done, 1'b0);
`ifdef RESET_SEQ_CAUSE_EN
    checkOutput("rst_cause", cause, 3'b001);
`endif
    rst_n = 1'b1;
    check_en = 1'b1;

    // Power-up sequence.
    waitEdge(5);  checkOutput("t1_e5", reset_out, 3'b111);
    waitEdge(6);  checkOutput("t1_e6", reset_out, 3'b110);
    waitEdge(7);  checkOutput("t1_e7", reset_out, 3'b110);
    waitEdge(8);  checkOutput("t1_e8", reset_out, 3'b100);
    waitEdge(9);  checkOutput("t1_e9_done", done, 1'b0);
    waitEdge(10); checkOutput("t1_e10", reset_out, 3'b000);
    checkOutput("t1_e10_done", done, 1'b1);
    checkOutput("t1_e10_busy", busy, 1'b0);

    // Soft request from RUN.
    waitEdge(20);
    applyStimulus(1, 1);
    checkOutput("t2_e21", reset_out, 3'b111);
    waitEdge(24); checkOutput("t2_e24", reset_out, 3'b111);
    waitEdge(25); checkOutput("t2_e25", reset_out, 3'b110);
    waitEdge(27); checkOutput("t2_e27", reset_out, 3'b100);
    waitEdge(29); checkOutput("t2_e29", reset_out, 3'b000);

    // Short async glitch from RUN.
    waitEdge(35);
    applyStimulus(2, 0);
    waitEdge(36 + SS);
    checkOutput("t3_latency", reset_out, 3'b111);
    waitEdge(async_hi + STR + 2 * STG + 10);
    checkOutput("t3_single", reset_out, 3'b000);

    // Async level held for 10 cycles.
    waitEdge(55);
    applyStimulus(3, 10);
    checkOutput("t4_level_end", reset_out, 3'b111);
    rel = async_hi + STR;
    waitEdge(rel - 1); checkOutput("t4_ch0_held", reset_out[0], 1'b1);
    waitEdge(rel);     checkOutput("t4_ch0_rel", reset_out[0], 1'b0);

    // Soft request on the edge ch1 would release.
    waitEdge(rel + STG - 1);
    applyStimulus(1, 1);
    checkOutput("t5_ch1_held", reset_out, 3'b111);
    rel = edge_n + STR;

    // Board reset pulse in the middle of RELEASE.
    waitEdge(rel + 1);
    checkOutput("t6_pre", reset_out, 3'b110);
    applyStimulus(4, 0);
    waitEdge(5); checkOutput("t6_e5", reset_out, 3'b111);
    waitEdge(6); checkOutput("t6_e6", reset_out, 3'b110);
    waitEdge(10); checkOutput("t6_e10", reset_out, 3'b000);

`ifdef RESET_SEQ_CAUSE_EN
    // Sticky cause bits.
    checkOutput("t7_por", cause, 3'b001);
    waitEdge(12);
    applyStimulus(1, 1);
    checkOutput("t7_soft", cause, 3'b011);
    applyStimulus(2, 0);
    waitEdge(async_lo);
    checkOutput("t7_async", cause, 3'b111);
    waitEdge(async_hi + 2);
    cause_clr = 1'b1;
    tick(1);
    cause_clr = 1'b0;
    checkOutput("t7_clr", cause, 3'b000);
    cause_clr = 1'b1;
    soft_req = 1'b1;
    tick(1);
    cause_clr = 1'b0;
    soft_req = 1'b0;
    checkOutput("t7_clr_set", cause, 3'b010);
`endif

    // Randomised mix of all request kinds, checked by the model.
    for (int i = 0; i < 80; i++) begin
      int kind;
      kind = $urandom_range(0, 9);
`ifdef RESET_SEQ_CAUSE_EN
      cause_clr = ($urandom_range(0, 3) == 0);
`endif
      if (kind <= 2) applyStimulus(0, $urandom_range(1, 12));
      else if (kind <= 4) applyStimulus(1, $urandom_range(1, 3));
      else if (kind <= 6) applyStimulus(2, 0);
      else if (kind <= 8) applyStimulus(3, $urandom_range(1, 8));
      else applyStimulus(4, 0);
`ifdef RESET_SEQ_CAUSE_EN
      cause_clr = 1'b0;
`endif
      if (kind >= 5 && kind <= 8) tick(2 * SS + 2);
    end
    tick(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
